// File: rtl/rtc_bus_pkg.sv
// Shared constants for the RTC bus-cycle engine: controller port map, command bits
// and the bus-cycle phase encoding.
package rtc_bus_pkg;

    localparam logic [7:0] PORT_ADDR  = 8'h01;
    localparam logic [7:0] PORT_WDATA = 8'h02;
    localparam logic [7:0] PORT_CMD   = 8'h03;

    localparam logic [7:0] IN_PORT_DATAO = 8'h0b;
    localparam logic [7:0] IN_PORT_DONEW = 8'h0c;
    localparam logic [7:0] IN_PORT_DONER = 8'h0d;

    localparam int CMD_WRITE_BIT = 0;
    localparam int CMD_READ_BIT  = 1;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        A_SETUP  = 3'd1,
        A_STROBE = 3'd2,
        A_HOLD   = 3'd3,
        GAP      = 3'd4,
        D_SETUP  = 3'd5,
        D_STROBE = 3'd6,
        D_HOLD   = 3'd7
    } phase_e;

    // Controller-side input-port mux used by the integrating top level.
    function automatic logic [7:0] ctrl_in_mux(input logic [7:0] pid,
                                               input logic [7:0] datao,
                                               input logic [7:0] donew,
                                               input logic [7:0] doner);
        logic [7:0] res;
        case (pid)
            IN_PORT_DATAO: res = datao;
            IN_PORT_DONEW: res = donew;
            IN_PORT_DONER: res = doner;
            default:       res = 8'h00;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/rtc_phase_timer.sv
// Loadable 8-bit down-counter that flags the last clock of a bus-cycle phase.
module rtc_phase_timer (
    input  logic       clock,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic       expire
);

    logic [7:0] count_q;
    logic [7:0] count_d;

    // Next count: reload on phase entry, otherwise count down and rest at zero.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (count_q != 8'd0) begin
            count_d = count_q - 8'd1;
        end else begin
            count_d = 8'd0;
        end
    end

    // Counter register.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire = (count_q == 8'd1);

endmodule

// File: rtl/rtc_bus_cycle.sv
// Bus-cycle engine: turns controller port writes into timed multiplexed address/data
// cycles towards the external RTC and reports read data and completion flags.
module rtc_bus_cycle
    import rtc_bus_pkg::*;
#(
    parameter int unsigned T_SETUP  = 2,
    parameter int unsigned T_STROBE = 10,
    parameter int unsigned T_HOLD   = 2,
    parameter int unsigned T_GAP    = 10
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] port_id,
    input  logic [7:0] out_port,
    input  logic       write_strobe,
    input  logic [7:0] ad_in,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    output logic       AD,
    output logic       CS,
    output logic       RD,
    output logic       WR,
    output logic [7:0] datao_rtc,
    output logic [7:0] donew,
    output logic [7:0] doner,
    output logic       busy
);

    localparam logic [7:0] T_SETUP_C  = 8'(T_SETUP);
    localparam logic [7:0] T_STROBE_C = 8'(T_STROBE);
    localparam logic [7:0] T_HOLD_C   = 8'(T_HOLD);
    localparam logic [7:0] T_GAP_C    = 8'(T_GAP);

    phase_e     state_q, state_d;
    logic       read_q, read_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;
    logic [7:0] datao_q, datao_d;
    logic       wdone_q, wdone_d;
    logic       rdone_q, rdone_d;
    logic       busy_q;
    logic       ad_sel_q, ad_sel_d;
    logic       cs_q, cs_d;
    logic       rd_q, rd_d;
    logic       wr_q, wr_d;
    logic       oe_q, oe_d;
    logic [7:0] out_q, out_d;
    logic       load_s;
    logic [7:0] load_val_s;
    logic       expire_s;

    rtc_phase_timer u_timer (
        .clock    (clock),
        .reset    (reset),
        .load     (load_s),
        .load_val (load_val_s),
        .expire   (expire_s)
    );

    // Register decode, command acceptance and phase sequencing.
    always_comb begin
        state_d    = state_q;
        read_d     = read_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        datao_d    = datao_q;
        wdone_d    = wdone_q;
        rdone_d    = rdone_q;
        load_s     = 1'b0;
        load_val_s = 8'd0;
        if (state_q == IDLE) begin
            if (write_strobe) begin
                case (port_id)
                    PORT_ADDR:  addr_d  = out_port;
                    PORT_WDATA: wdata_d = out_port;
                    PORT_CMD: begin
                        // A command with both bits set is treated as a write.
                        if (out_port[CMD_WRITE_BIT]) begin
                            read_d     = 1'b0;
                            wdone_d    = 1'b0;
                            state_d    = A_SETUP;
                            load_s     = 1'b1;
                            load_val_s = T_SETUP_C;
                        end else if (out_port[CMD_READ_BIT]) begin
                            read_d     = 1'b1;
                            rdone_d    = 1'b0;
                            state_d    = A_SETUP;
                            load_s     = 1'b1;
                            load_val_s = T_SETUP_C;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end else begin
                state_d = IDLE;
            end
        end else if (expire_s) begin
            load_s = 1'b1;
            case (state_q)
                A_SETUP:  begin state_d = A_STROBE; load_val_s = T_STROBE_C; end
                A_STROBE: begin state_d = A_HOLD;   load_val_s = T_HOLD_C;   end
                A_HOLD:   begin state_d = GAP;      load_val_s = T_GAP_C;    end
                GAP:      begin state_d = D_SETUP;  load_val_s = T_SETUP_C;  end
                D_SETUP:  begin state_d = D_STROBE; load_val_s = T_STROBE_C; end
                D_STROBE: begin
                    state_d    = D_HOLD;
                    load_val_s = T_HOLD_C;
                    if (read_q) begin
                        datao_d = ad_in;
                    end else begin
                        datao_d = datao_q;
                    end
                end
                D_HOLD: begin
                    state_d = IDLE;
                    load_s  = 1'b0;
                    if (read_q) begin
                        rdone_d = 1'b1;
                    end else begin
                        wdone_d = 1'b1;
                    end
                end
                default: begin state_d = IDLE; load_s = 1'b0; end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Bus levels for the phase being entered, so the pins change on the same edge as the state.
    always_comb begin
        ad_sel_d = 1'b1;
        cs_d     = 1'b1;
        rd_d     = 1'b1;
        wr_d     = 1'b1;
        oe_d     = 1'b0;
        out_d    = 8'h00;
        case (state_d)
            A_SETUP, A_HOLD: begin
                ad_sel_d = 1'b0;
                oe_d     = 1'b1;
                out_d    = addr_d;
            end
            A_STROBE: begin
                ad_sel_d = 1'b0;
                cs_d     = 1'b0;
                wr_d     = 1'b0;
                oe_d     = 1'b1;
                out_d    = addr_d;
            end
            D_SETUP, D_HOLD: begin
                if (read_d) begin
                    oe_d = 1'b0;
                end else begin
                    oe_d  = 1'b1;
                    out_d = wdata_d;
                end
            end
            D_STROBE: begin
                cs_d = 1'b0;
                if (read_d) begin
                    rd_d = 1'b0;
                end else begin
                    wr_d  = 1'b0;
                    oe_d  = 1'b1;
                    out_d = wdata_d;
                end
            end
            default: oe_d = 1'b0;
        endcase
    end

    // State, holding registers and registered bus outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            read_q   <= 1'b0;
            addr_q   <= 8'h00;
            wdata_q  <= 8'h00;
            datao_q  <= 8'h00;
            wdone_q  <= 1'b0;
            rdone_q  <= 1'b0;
            busy_q   <= 1'b0;
            ad_sel_q <= 1'b1;
            cs_q     <= 1'b1;
            rd_q     <= 1'b1;
            wr_q     <= 1'b1;
            oe_q     <= 1'b0;
            out_q    <= 8'h00;
        end else begin
            state_q  <= state_d;
            read_q   <= read_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            datao_q  <= datao_d;
            wdone_q  <= wdone_d;
            rdone_q  <= rdone_d;
            busy_q   <= (state_d != IDLE);
            ad_sel_q <= ad_sel_d;
            cs_q     <= cs_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            oe_q     <= oe_d;
            out_q    <= out_d;
        end
    end

    assign ad_out    = out_q;
    assign ad_oe     = oe_q;
    assign AD        = ad_sel_q;
    assign CS        = cs_q;
    assign RD        = rd_q;
    assign WR        = wr_q;
    assign datao_rtc = datao_q;
    assign donew     = {7'b0, wdone_q};
    assign doner     = {7'b0, rdone_q};
    assign busy      = busy_q;

endmodule

// File: tb/tb_rtc_bus_cycle.sv
// Self-checking bench for rtc_bus_cycle: a cycle-offset model of the bus waveform
// compared every cycle, plus directed scenarios with literal expectations.
module tb_rtc_bus_cycle;

    localparam int TS = 2, TST = 10, TH = 2, TG = 10;
    localparam int N  = 2 * (TS + TST + TH) + TG;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] port_id, out_port;
    logic       write_strobe;
    logic [7:0] ad_in, ad_out, datao_rtc, donew, doner;
    logic       ad_oe, AD, CS, RD, WR, busy;
    logic [7:0] rd_val;

    int n_checks = 0;
    int n_errors = 0;

    rtc_bus_cycle #(.T_SETUP(TS), .T_STROBE(TST), .T_HOLD(TH), .T_GAP(TG)) dut (
        .clock(clock), .reset(reset), .port_id(port_id), .out_port(out_port),
        .write_strobe(write_strobe), .ad_in(ad_in), .ad_out(ad_out), .ad_oe(ad_oe),
        .AD(AD), .CS(CS), .RD(RD), .WR(WR), .datao_rtc(datao_rtc),
        .donew(donew), .doner(doner), .busy(busy)
    );

    always #5 clock = ~clock;

    // RTC chip model: puts rd_val on the bus while RD is low.
    assign ad_in = RD ? 8'h00 : rd_val;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Model: register values, current cycle start and sticky flags, advanced per clock edge.
    int         cyc = 0;
    int         k = 0;
    bit         m_valid = 0, active = 0, m_read = 0, idle_before;
    logic [7:0] m_addr = 0, m_wdata = 0, m_datao = 0, c_addr = 0, c_wdata = 0;
    bit         m_wdone = 0, m_rdone = 0;

    always @(posedge clock) begin
        cyc = cyc + 1;
        if (reset) begin
            m_valid = 1; active = 0; m_addr = 0; m_wdata = 0;
            m_datao = 0; m_wdone = 0; m_rdone = 0;
        end else if (m_valid) begin
            idle_before = !active;
            if (active && m_read && cyc == k + N - TH) m_datao = rd_val;
            if (active && cyc == k + N) begin
                active = 0;
                if (m_read) m_rdone = 1; else m_wdone = 1;
            end
            if (idle_before && write_strobe) begin
                if (port_id == 8'h01) m_addr = out_port;
                else if (port_id == 8'h02) m_wdata = out_port;
                else if (port_id == 8'h03 && out_port[1:0] != 2'b00) begin
                    m_read = !out_port[0];
                    if (m_read) m_rdone = 0; else m_wdone = 0;
                    active = 1; k = cyc; c_addr = m_addr; c_wdata = m_wdata;
                end
            end
        end
    end

    // Compare process: expected bus levels derived from the offset into the cycle.
    int         o;
    logic       e_ad, e_cs, e_rd, e_wr, e_oe, e_busy;
    logic [7:0] e_out;
    always @(negedge clock) begin
        if (m_valid && !reset) begin
            e_ad = 1; e_cs = 1; e_rd = 1; e_wr = 1; e_oe = 0; e_out = 8'h00; e_busy = 0;
            if (active) begin
                o = cyc - k;
                e_busy = 1;
                if (o < TS + TST + TH) begin
                    e_ad = 0; e_oe = 1; e_out = c_addr;
                    if (o >= TS && o < TS + TST) begin e_cs = 0; e_wr = 0; end
                end else if (o >= TS + TST + TH + TG) begin
                    e_oe = !m_read; e_out = c_wdata;
                    if (o >= N - TH - TST && o < N - TH) begin
                        e_cs = 0;
                        if (m_read) e_rd = 0; else e_wr = 0;
                    end
                end
            end
            chk("AD", AD, e_ad);
            chk("CS", CS, e_cs);
            chk("RD", RD, e_rd);
            chk("WR", WR, e_wr);
            chk("ad_oe", ad_oe, e_oe);
            if (e_oe) chk("ad_out", ad_out, e_out);
            chk("busy", busy, e_busy);
            chk("donew", donew, {7'b0, m_wdone});
            chk("doner", doner, {7'b0, m_rdone});
            chk("datao_rtc", datao_rtc, m_datao);
        end
    end

    // Strobe census used by the directed scenarios.
    int wr_lo_a = 0, wr_lo_d = 0, rd_lo_a = 0, rd_lo_d = 0, oe_in_rd = 0, wr_a21 = 0;
    always @(negedge clock) begin
        if (!WR && !AD) wr_lo_a++;
        if (!WR && AD) wr_lo_d++;
        if (!RD && !AD) rd_lo_a++;
        if (!RD && AD) rd_lo_d++;
        if (!RD && ad_oe) oe_in_rd++;
        if (!WR && !AD && ad_out == 8'h21) wr_a21++;
    end

    task automatic clr_counts();
        wr_lo_a = 0; wr_lo_d = 0; rd_lo_a = 0; rd_lo_d = 0; oe_in_rd = 0; wr_a21 = 0;
    endtask

    // One controller write; returns just after the capturing edge.
    task automatic wr_port(input logic [7:0] p, input logic [7:0] d);
        @(posedge clock); #1;
        port_id = p; out_port = d; write_strobe = 1'b1;
        @(posedge clock); #1;
        write_strobe = 1'b0;
    endtask

    initial begin
        reset = 1'b1; port_id = 8'h00; out_port = 8'h00; write_strobe = 1'b0; rd_val = 8'h00;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk("rst_strobes", {AD, CS, RD, WR}, 4'hF);
        chk("rst_oe_busy", {ad_oe, busy}, 2'b00);
        chk("rst_ad_out", ad_out, 8'h00);
        chk("rst_done", {donew, doner}, 16'h0000);

        // Write 0x45 to address 0x21.
        wr_port(8'h01, 8'h21); wr_port(8'h02, 8'h45);
        clr_counts();
        wr_port(8'h03, 8'h01);
        repeat (N) @(negedge clock);
        chk("w_donew_early", donew, 8'h00);
        chk("w_busy_late", busy, 1'b1);
        @(negedge clock);
        chk("w_donew_38", donew, 8'h01);
        chk("w_busy_end", busy, 1'b0);
        chk("w_wr_lo_addr", wr_lo_a, 10);
        chk("w_wr_lo_data", wr_lo_d, 10);

        // Register and command writes while busy are dropped.
        clr_counts();
        wr_port(8'h03, 8'h01);
        wr_port(8'h01, 8'hFF); wr_port(8'h03, 8'h02);
        repeat (N + 12) @(negedge clock);
        chk("ign_doner", doner, 8'h00);
        chk("ign_busy", busy, 1'b0);
        chk("ign_addr_strobes", wr_lo_a, 10);
        chk("ign_addr_21", wr_a21, 10);
        chk("ign_no_read", rd_lo_d, 0);

        // Read from address 0x22, chip returns 0x59.
        rd_val = 8'h59;
        wr_port(8'h01, 8'h22);
        clr_counts();
        wr_port(8'h03, 8'h02);
        repeat (N) @(negedge clock);
        chk("r_doner_early", doner, 8'h00);
        @(negedge clock);
        chk("r_doner_38", doner, 8'h01);
        chk("r_datao", datao_rtc, 8'h59);
        chk("r_rd_in_addr", rd_lo_a, 0);
        chk("r_rd_lo_data", rd_lo_d, 10);
        chk("r_oe_during_rd", oe_in_rd, 0);
        chk("r_wr_lo_addr", wr_lo_a, 10);

        // Reset in the middle of a write data strobe.
        wr_port(8'h03, 8'h01);
        repeat (30) @(posedge clock);
        #1 reset = 1'b1;
        @(negedge clock);
        chk("mid_in_dstrobe", {CS, WR}, 2'b00);
        @(negedge clock);
        chk("mid_strobes", {AD, CS, RD, WR}, 4'hF);
        chk("mid_oe_busy", {ad_oe, busy}, 2'b00);
        chk("mid_done", {donew, doner}, 16'h0000);
        chk("mid_datao", datao_rtc, 8'h00);
        @(posedge clock); #1 reset = 1'b0;

        // Command 0x03 runs a write; a read on the first idle cycle is accepted.
        wr_port(8'h01, 8'h22); wr_port(8'h02, 8'h66);
        wr_port(8'h03, 8'h03);
        repeat (N - 1) @(posedge clock);
        rd_val = 8'hA7;
        clr_counts();
        wr_port(8'h03, 8'h02);
        chk("b2b_busy", busy, 1'b1);
        repeat (N + 1) @(negedge clock);
        chk("b2b_donew", donew, 8'h01);
        chk("b2b_doner", doner, 8'h01);
        chk("b2b_datao", datao_rtc, 8'hA7);
        chk("b2b_rd_lo", rd_lo_d, 10);

        repeat (4) @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
